ht_head_wr_arb: RTL

Write-side arbiter and clear sequencer for the head table. It merges head-pointer update requests from the insert and delete units into the single head-table write port, with round-robin fairness. It also owns the table-clear procedure: it gates pipeline ingress, waits for in-flight traffic to drain, runs the head-table clear, and reports completion. It sits between the insert/delete engines and `head_table_if`, next to the head-table lookup stage.

---
 rtl/ht_head_wr_arb_pkg.sv | 23 ++
 rtl/ht_head_wr_arb_chk.sv | 43 ++++
 rtl/ht_head_wr_arb_rr_arbiter.sv | 55 +++++
 rtl/ht_head_wr_arb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ht_head_wr_arb_pkg.sv
// Shared head-table types for the hash_table block family.
//   BUCKET_WIDTH / HEAD_PTR_WIDTH : head-table address and pointer widths
//   ht_head_wr_req_t              : one head-table write request
//   ht_clr_state_t                : table-clear sequencer states
package hash_table;

  localparam int BUCKET_WIDTH   = 8;
  localparam int HEAD_PTR_WIDTH = 6;

  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]   addr;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } ht_head_wr_req_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_DRAIN = 2'd1,
    CLR_CLEAR = 2'd2,
    CLR_DONE  = 2'd3
  } ht_clr_state_t;

endpackage

// File: rtl/ht_head_wr_arb_chk.sv
// Protocol checker for ht_head_wr_arb (simulation assertions only).
//   pipe_in_fire_i/pipe_out_fire_i : pipeline enter/retire pulses
//   ingress_en_i                   : current ingress permit
//   inflight_i                     : in-flight counter value
//   gnt_i, rr_last_i               : arbiter grant and winner history
module ht_head_wr_arb_chk #(
  parameter  int N_REQ      = 2,
  parameter  int INFLIGHT_W = 6,
  localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  pipe_in_fire_i,
  input logic                  pipe_out_fire_i,
  input logic                  ingress_en_i,
  input logic [INFLIGHT_W-1:0] inflight_i,
  input logic [N_REQ-1:0]      gnt_i,
  input logic [IW-1:0]         rr_last_i
);

  localparam logic [INFLIGHT_W-1:0] INFL_MAX = '1;

  a_inc_at_max: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_in_fire_i && !pipe_out_fire_i && (inflight_i == INFL_MAX)))
    else $error("in-flight counter incremented at maximum");

  a_dec_at_zero: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_out_fire_i && !pipe_in_fire_i && (inflight_i == '0)))
    else $error("in-flight counter decremented at zero");

  a_in_gated: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_in_fire_i && !ingress_en_i))
    else $error("pipeline ingress while ingress is gated");

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_i))
    else $error("arbiter grant not one-hot");

  a_rr_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (int'(rr_last_i) < N_REQ))
    else $error("arbiter history index out of range");

endmodule

// File: rtl/ht_head_wr_arb_rr_arbiter.sv
// Generic round-robin arbiter, shared by the head- and data-table write ports.
//   clk_i, rst_i : clock, async active-high reset
//   req          : per-requester request vector
//   en           : arbitration enable; no grant while low
//   gnt          : combinational one-hot (or zero) grant
//   rr_last      : index of the most recent winner
module ht_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] rr_last
);

  logic [IW-1:0] rr_last_r;
  logic [IW-1:0] gnt_idx_s;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Rotating-priority search that starts one slot past the last winner
  always_comb begin
    gnt       = '0;
    gnt_idx_s = rr_last_r;
    idx_s     = '0;
    found_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_s = IW'((int'(rr_last_r) + k) % N);
      if (en && req[idx_s] && !found_s) begin
        gnt[idx_s] = 1'b1;
        gnt_idx_s  = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner history; resets to N-1 so that requester 0 has first priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_r <= IW'(N - 1);
    end else if (found_s) begin
      rr_last_r <= gnt_idx_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign rr_last = rr_last_r;

endmodule

// File: rtl/ht_head_wr_arb.sv
// Head-table write-port arbiter and table-clear sequencer.
//   req_valid_i/req_i/req_ready_o : insert(0)/delete(1) write requests, RR arbitrated
//   wr_en_o/wr_addr_o/wr_data_*   : registered head-table write port
//   pipe_in/out_fire_i            : pdata enter/retire pulses for the in-flight count
//   ingress_en_o                  : ingress permit, low while a clear is in progress
//   clear_req_i/clear_ram_run_o/clear_ram_done_i/clear_done_o : clear handshake
//   busy_o                        : clear sequence in progress
module ht_head_wr_arb
  import hash_table::*;
#(
  parameter int N_REQ      = 2,
  parameter int INFLIGHT_W = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  ht_head_wr_req_t [N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          wr_en_o,
  output logic [BUCKET_WIDTH-1:0]       wr_addr_o,
  output logic [HEAD_PTR_WIDTH-1:0]     wr_data_ptr_o,
  output logic                          wr_data_ptr_val_o,
  input  logic                          pipe_in_fire_i,
  input  logic                          pipe_out_fire_i,
  output logic                          ingress_en_o,
  input  logic                          clear_req_i,
  output logic                          clear_ram_run_o,
  input  logic                          clear_ram_done_i,
  output logic                          clear_done_o,
  output logic                          busy_o
);

  localparam int                    IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [INFLIGHT_W-1:0] INFL_MAX = '1;

  ht_clr_state_t         state_r;
  logic                  arb_en_s;
  logic [N_REQ-1:0]      gnt_s;
  logic [IW-1:0]         rr_last_s;
  ht_head_wr_req_t       win_req_s;
  logic [INFLIGHT_W-1:0] inflight_r;
  logic                  wr_en_r;
  ht_head_wr_req_t       wr_req_r;
  logic                  ingress_en_r;
  logic                  clear_run_r;
  logic                  clear_done_r;
  logic                  busy_r;

  // New writes are only accepted while no clear is in progress
  assign arb_en_s = (state_r == CLR_IDLE);

  ht_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_valid_i),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .rr_last (rr_last_s)
  );

  // AND-OR select of the winning request (grant is one-hot or zero)
  always_comb begin
    win_req_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        win_req_s = win_req_s | req_i[i];
      end else begin
        win_req_s = win_req_s;
      end
    end
  end

  // Write register: strobe for one cycle per grant, data holds otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_en_r  <= 1'b0;
      wr_req_r <= '0;
    end else if (|gnt_s) begin
      wr_en_r  <= 1'b1;
      wr_req_r <= win_req_s;
    end else begin
      wr_en_r  <= 1'b0;
    end
  end

  // In-flight pdata counter; saturates instead of wrapping on misuse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_r <= '0;
    end else begin
      case ({pipe_in_fire_i, pipe_out_fire_i})
        2'b10: begin
          if (inflight_r != INFL_MAX) inflight_r <= inflight_r + INFLIGHT_W'(1);
          else                        inflight_r <= inflight_r;
        end
        2'b01: begin
          if (inflight_r != '0) inflight_r <= inflight_r - INFLIGHT_W'(1);
          else                  inflight_r <= inflight_r;
        end
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Clear sequencer with registered status/pulse outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= CLR_IDLE;
      ingress_en_r <= 1'b1;
      clear_run_r  <= 1'b0;
      clear_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      clear_run_r  <= 1'b0;
      clear_done_r <= 1'b0;
      case (state_r)
        CLR_IDLE: begin
          if (clear_req_i) begin
            state_r      <= CLR_DRAIN;
            ingress_en_r <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        CLR_DRAIN: begin
          // A write granted alongside the clear request must land first
          if ((inflight_r == '0) && !wr_en_r) begin
            state_r     <= CLR_CLEAR;
            clear_run_r <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          if (clear_ram_done_i) begin
            state_r      <= CLR_DONE;
            clear_done_r <= 1'b1;
          end
        end
        CLR_DONE: begin
          state_r      <= CLR_IDLE;
          ingress_en_r <= 1'b1;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r      <= CLR_IDLE;
          ingress_en_r <= 1'b1;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o       = gnt_s;
  assign wr_en_o           = wr_en_r;
  assign wr_addr_o         = wr_req_r.addr;
  assign wr_data_ptr_o     = wr_req_r.ptr;
  assign wr_data_ptr_val_o = wr_req_r.ptr_val;
  assign ingress_en_o      = ingress_en_r;
  assign clear_ram_run_o   = clear_run_r;
  assign clear_done_o      = clear_done_r;
  assign busy_o            = busy_r;

  ht_head_wr_arb_chk #(.N_REQ(N_REQ), .INFLIGHT_W(INFLIGHT_W)) u_chk (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pipe_in_fire_i  (pipe_in_fire_i),
    .pipe_out_fire_i (pipe_out_fire_i),
    .ingress_en_i    (ingress_en_r),
    .inflight_i      (inflight_r),
    .gnt_i           (gnt_s),
    .rr_last_i       (rr_last_s)
  );

endmodule
